// File: rtl/phys_free_list.sv
// phys_free_list: physical-register free list for the rename stage.
// A circular FIFO of free physical indices. Allocation is all-or-nothing
// across ALLOC_PORTS; up to FREE_PORTS indices are returned per cycle.
// Optional build macro: FREE_LIST_CHECK_EN adds an in_free tracking vector
// and raises err_double_free on duplicate or already-free releases.
module phys_free_list #(
    parameter int PHYS_COUNT      = 128,
    parameter int ARCH_COUNT      = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT),
    parameter int CNT_WIDTH       = $clog2(PHYS_COUNT + 1)
) (
    input  logic                                          clk,
    input  logic                                          sync_rst,
    input  logic                                          clk_en,
    // Allocate handshake: alloc_req is a group request. alloc_grant is
    // combinational and is high only when every requesting port can be
    // served; alloc_addr is meaningful only in a cycle with alloc_grant
    // high, and the indices are consumed at the next rising clock edge.
    input  logic [ALLOC_PORTS-1:0]                        alloc_req,
    output logic                                          alloc_grant,
    output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]   alloc_addr,
    input  logic [FREE_PORTS-1:0]                         free_en,
    input  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]    free_addr,
    output logic [CNT_WIDTH-1:0]                          free_count,
    output logic                                          empty,
    output logic                                          err_overflow,
    output logic                                          err_double_free
);

    localparam int AW        = $clog2(ALLOC_PORTS + 1);
    localparam int FW        = $clog2(FREE_PORTS + 1);
    localparam int INIT_FREE = PHYS_COUNT - ARCH_COUNT;

    logic [PHYS_ADDR_WIDTH-1:0]                      mem [PHYS_COUNT];
    logic [PHYS_ADDR_WIDTH-1:0]                      head;
    logic [PHYS_ADDR_WIDTH-1:0]                      tail;
    logic [CNT_WIDTH-1:0]                            count;
    logic [AW-1:0]                                   n_alloc;
    logic [FW-1:0]                                   n_free;
    logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]      free_slot;
    logic [CNT_WIDTH:0]                              count_after_alloc;
    logic [CNT_WIDTH:0]                              count_next_raw;
    logic                                            free_overflow;
    logic                                            free_accept;

    // Allocate side: compact requesting ports onto consecutive head slots.
    always_comb begin
        logic [PHYS_ADDR_WIDTH-1:0] slot;
        n_alloc    = '0;
        alloc_addr = '0;
        slot       = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            slot = head + PHYS_ADDR_WIDTH'(n_alloc);
            if (alloc_req[i]) begin
                alloc_addr[i] = mem[slot];
            end
            n_alloc = n_alloc + AW'(alloc_req[i]);
        end
    end

    assign alloc_grant = clk_en && (n_alloc != '0) && (count >= CNT_WIDTH'(n_alloc));

    // Free side: compact enabled ports onto consecutive tail slots.
    always_comb begin
        n_free    = '0;
        free_slot = '0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            free_slot[i] = tail + PHYS_ADDR_WIDTH'(n_free);
            n_free       = n_free + FW'(free_en[i]);
        end
    end

    // Count arithmetic one bit wider so a too-large free group is detectable.
    always_comb begin
        count_after_alloc = {1'b0, count} - (alloc_grant ? (CNT_WIDTH+1)'(n_alloc) : '0);
        count_next_raw    = count_after_alloc + (CNT_WIDTH+1)'(n_free);
        free_overflow     = count_next_raw > (CNT_WIDTH+1)'(PHYS_COUNT);
        free_accept       = clk_en && (n_free != '0) && !free_overflow;
    end

    // Per-entry storage, so each slot has one writer and its own reset value.
    for (genvar k = 0; k < PHYS_COUNT; k++) begin : g_entry
        logic [PHYS_ADDR_WIDTH-1:0] q;
        logic                       we;
        logic [PHYS_ADDR_WIDTH-1:0] wd;

        // Find the free port (if any) that lands on this slot.
        always_comb begin
            we = 1'b0;
            wd = '0;
            for (int i = 0; i < FREE_PORTS; i++) begin
                if (free_accept && free_en[i] && (free_slot[i] == PHYS_ADDR_WIDTH'(k))) begin
                    we = 1'b1;
                    wd = free_addr[i];
                end
            end
        end

        // Entry register: reset to its initial free index, else take a release.
        always_ff @(posedge clk) begin
            if (sync_rst) begin
                q <= (k < INIT_FREE) ? PHYS_ADDR_WIDTH'(ARCH_COUNT + k) : '0;
            end else if (clk_en && we) begin
                q <= wd;
            end
        end

        assign mem[k] = q;
    end

    // Pointers, count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            head         <= '0;
            tail         <= PHYS_ADDR_WIDTH'(INIT_FREE);
            count        <= CNT_WIDTH'(INIT_FREE);
            err_overflow <= 1'b0;
        end else if (clk_en) begin
            if (alloc_grant) begin
                head <= head + PHYS_ADDR_WIDTH'(n_alloc);
            end
            if (free_accept) begin
                tail  <= tail + PHYS_ADDR_WIDTH'(n_free);
                count <= count_next_raw[CNT_WIDTH-1:0];
            end else begin
                count <= count_after_alloc[CNT_WIDTH-1:0];
            end
            if (free_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign free_count = count;
    assign empty      = (count == '0);

`ifdef FREE_LIST_CHECK_EN
    logic [PHYS_COUNT-1:0] in_free;
    logic [PHYS_COUNT-1:0] in_free_next;
    logic                  dbl_hit;

    function automatic logic [PHYS_COUNT-1:0] reset_mask();
        logic [PHYS_COUNT-1:0] m;
        m = '0;
        for (int k = ARCH_COUNT; k < PHYS_COUNT; k++) begin
            m[k] = 1'b1;
        end
        return m;
    endfunction

    // Detect releases of already-free indices or duplicates within one group.
    always_comb begin
        dbl_hit = 1'b0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            if (free_en[i]) begin
                if (in_free[free_addr[i]]) begin
                    dbl_hit = 1'b1;
                end
                for (int j = i + 1; j < FREE_PORTS; j++) begin
                    if (free_en[j] && (free_addr[j] == free_addr[i])) begin
                        dbl_hit = 1'b1;
                    end
                end
            end
        end
    end

    // Next membership: granted allocations leave, accepted releases rejoin.
    always_comb begin
        in_free_next = in_free;
        if (alloc_grant) begin
            for (int i = 0; i < ALLOC_PORTS; i++) begin
                if (alloc_req[i]) begin
                    in_free_next[alloc_addr[i]] = 1'b0;
                end
            end
        end
        if (free_accept) begin
            for (int i = 0; i < FREE_PORTS; i++) begin
                if (free_en[i]) begin
                    in_free_next[free_addr[i]] = 1'b1;
                end
            end
        end
    end

    // Membership register and sticky double-free flag.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            in_free         <= reset_mask();
            err_double_free <= 1'b0;
        end else if (clk_en) begin
            in_free <= in_free_next;
            if (dbl_hit) begin
                err_double_free <= 1'b1;
            end
        end
    end
`else
    assign err_double_free = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list with default parameters
// (128 physical, 32 architectural, 4 alloc ports, 4 free ports).
module tb_phys_free_list;

    localparam int W  = 7;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              sync_rst;
    logic              clk_en;
    logic [3:0]        alloc_req;
    logic              alloc_grant;
    logic [3:0][W-1:0] alloc_addr;
    logic [3:0]        free_en;
    logic [3:0][W-1:0] free_addr;
    logic [CW-1:0]     free_count;
    logic              empty;
    logic              err_overflow;
    logic              err_double_free;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    phys_free_list dut (
        .clk             (clk),
        .sync_rst        (sync_rst),
        .clk_en          (clk_en),
        .alloc_req       (alloc_req),
        .alloc_grant     (alloc_grant),
        .alloc_addr      (alloc_addr),
        .free_en         (free_en),
        .free_addr       (free_addr),
        .free_count      (free_count),
        .empty           (empty),
        .err_overflow    (err_overflow),
        .err_double_free (err_double_free)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every alloc port against the front of the expected queue.
    task automatic check_alloc(input string tag);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] e;
            e = '0;
            if (alloc_req[i] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end
            chk($sformatf("%s[%0d]", tag, i), 32'(alloc_addr[i]), 32'(e));
        end
    endtask

    initial begin
        sync_rst  = 1'b1;
        clk_en    = 1'b1;
        alloc_req = '0;
        free_en   = '0;
        free_addr = '0;
        for (int k = 32; k < 128; k++) exp_q.push_back(W'(k));

        // Reset and idle state
        repeat (2) tick();
        sync_rst = 1'b0;
        #1;
        chk("rst_count", 32'(free_count), 96);
        chk("rst_empty", 32'(empty), 0);
        chk("rst_grant", 32'(alloc_grant), 0);
        chk("rst_ovf", 32'(err_overflow), 0);
        chk("rst_dbl", 32'(err_double_free), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_addr[%0d]", i), 32'(alloc_addr[i]), 0);

        // clk_en low freezes everything
        clk_en    = 1'b0;
        alloc_req = 4'b1111;
        free_en   = 4'b0001;
        free_addr[0] = 7'd3;
        #1;
        chk("cen_grant", 32'(alloc_grant), 0);
        tick();
        clk_en    = 1'b1;
        alloc_req = '0;
        free_en   = '0;
        #1;
        chk("cen_count", 32'(free_count), 96);

        // First allocations
        alloc_req = 4'b1111;
        #1;
        chk("a1_grant", 32'(alloc_grant), 1);
        check_alloc("a1_addr");
        tick();
        alloc_req = '0;
        #1;
        chk("a1_count", 32'(free_count), 92);
        alloc_req = 4'b1010;
        #1;
        chk("a2_grant", 32'(alloc_grant), 1);
        check_alloc("a2_addr");
        tick();

        // Drain down to 2
        for (int c = 0; c < 22; c++) begin
            alloc_req = 4'b1111;
            #1;
            chk("drain_grant", 32'(alloc_grant), 1);
            check_alloc("drain_addr");
            tick();
        end
        alloc_req = '0;
        #1;
        chk("low_count", 32'(free_count), 2);
        chk("low_empty", 32'(empty), 0);

        // Request larger than supply is refused whole
        alloc_req = 4'b0111;
        #1;
        chk("big_grant", 32'(alloc_grant), 0);
        tick();
        alloc_req = '0;
        #1;
        chk("big_count", 32'(free_count), 2);
        alloc_req = 4'b0011;
        #1;
        chk("last_grant", 32'(alloc_grant), 1);
        check_alloc("last_addr");
        tick();
        alloc_req = '0;
        #1;
        chk("zero_count", 32'(free_count), 0);
        chk("zero_empty", 32'(empty), 1);

        // Free at empty: not allocatable in the same cycle
        alloc_req    = 4'b0001;
        free_en      = 4'b0001;
        free_addr[0] = 7'd5;
        #1;
        chk("fe_grant", 32'(alloc_grant), 0);
        exp_q.push_back(7'd5);
        tick();
        free_en = '0;
        #1;
        chk("fe_count", 32'(free_count), 1);
        chk("fe_grant2", 32'(alloc_grant), 1);
        check_alloc("fe_addr");
        tick();
        alloc_req = '0;
        #1;
        chk("fe_count2", 32'(free_count), 0);

        // Wrap-around: free four, allocate the previous four, each round
        for (int r = 0; r < 40; r++) begin
            alloc_req = 4'b1111;
            free_en   = 4'b1111;
            for (int k = 0; k < 4; k++) free_addr[k] = W'(((r * 4 + k) * 7 + 3) % 128);
            #1;
            chk("wrap_grant", 32'(alloc_grant), 32'(r != 0));
            if (r != 0) check_alloc("wrap_addr");
            for (int k = 0; k < 4; k++) exp_q.push_back(free_addr[k]);
            tick();
            chk("wrap_count", 32'(free_count), 4);
        end
        free_en = '0;
        #1;
        chk("wrapd_grant", 32'(alloc_grant), 1);
        check_alloc("wrapd_addr");
        tick();
        alloc_req = '0;
        #1;
        chk("wrapd_count", 32'(free_count), 0);

        // Fill to 127, then overflow with two more
        for (int c = 0; c < 31; c++) begin
            free_en = 4'b1111;
            for (int k = 0; k < 4; k++) free_addr[k] = W'(c * 4 + k);
            tick();
        end
        free_en = 4'b0111;
        for (int k = 0; k < 3; k++) free_addr[k] = W'(124 + k);
        tick();
        free_en = '0;
        #1;
        chk("fill_count", 32'(free_count), 127);
        chk("fill_ovf", 32'(err_overflow), 0);
        free_en      = 4'b0011;
        free_addr[0] = 7'd1;
        free_addr[1] = 7'd2;
        tick();
        free_en = '0;
        #1;
        chk("ovf_count", 32'(free_count), 127);
        chk("ovf_flag", 32'(err_overflow), 1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(err_overflow), 1);
        free_en      = 4'b0001;
        free_addr[0] = 7'd127;
        tick();
        free_en = '0;
        #1;
        chk("full_count", 32'(free_count), 128);
        chk("full_ovf", 32'(err_overflow), 1);

        // Reset clears sticky flags
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        #1;
        chk("rst2_ovf", 32'(err_overflow), 0);
        chk("rst2_count", 32'(free_count), 96);

        // Release of an index already on the list
        free_en      = 4'b0001;
        free_addr[0] = 7'd40;
        tick();
        free_en = '0;
        #1;
        chk("dbl_count", 32'(free_count), 97);
`ifdef FREE_LIST_CHECK_EN
        chk("dbl_flag", 32'(err_double_free), 1);
`else
        chk("dbl_flag", 32'(err_double_free), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Physical-register free list for the rename stage.
- Supplies free physical register indices to the allocate side, which writes new mappings into the map table.
- Reclaims indices released at commit, when an old mapping is overwritten.
- Circular FIFO of physical indices with multi-port, all-or-nothing allocate and multi-port free.

Parameters:
- PHYS_COUNT, 128, number of physical registers; must be a power of two.
- ARCH_COUNT, 32, architectural registers; indices 0..ARCH_COUNT-1 are mapped at reset and are not on the list.
- ALLOC_PORTS, 4, allocate ports per cycle.
- FREE_PORTS, 4, free ports per cycle.
- PHYS_ADDR_WIDTH, $clog2(PHYS_COUNT), physical index width.
- CNT_WIDTH, $clog2(PHYS_COUNT+1), free-count width.

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous reset, active-high
- clk_en  in  1  global enable; when low, no state changes
- alloc_req  in  ALLOC_PORTS  per-port allocate request
- alloc_grant  out  1  whole request group accepted this cycle
- alloc_addr  out  PHYS_ADDR_WIDTH x ALLOC_PORTS  allocated index per port
- free_en  in  FREE_PORTS  per-port release
- free_addr  in  PHYS_ADDR_WIDTH x FREE_PORTS  released index per port
- free_count  out  CNT_WIDTH  registered number of free entries
- empty  out  1  free_count == 0
- err_overflow  out  1  sticky; a free group was dropped
- err_double_free  out  1  sticky; only meaningful with FREE_LIST_CHECK_EN

Behaviour:
- Storage: PHYS_COUNT-entry array; head and tail pointers of PHYS_ADDR_WIDTH bits wrap modulo PHYS_COUNT; registered count.
- Reset (sync_rst high at posedge):
  - entry[k] = ARCH_COUNT+k for k < PHYS_COUNT-ARCH_COUNT; other entries 0.
  - head = 0, tail = PHYS_COUNT-ARCH_COUNT (wraps to 0 when equal to PHYS_COUNT), count = PHYS_COUNT-ARCH_COUNT.
  - err_overflow = 0, err_double_free = 0.
  - Reset takes priority over all other activity, including mid-operation.
- Allocate (combinational, same cycle):
  - n_alloc = popcount(alloc_req).
  - rank(i) = number of set alloc_req bits below i.
  - alloc_addr[i] = entry[head+rank(i)] when alloc_req[i] is set; otherwise 0.
  - alloc_grant = clk_en & (n_alloc != 0) & (count >= n_alloc).
  - All-or-nothing: no partial grants. alloc_addr is valid only when alloc_grant is high.
  - On a granted edge: head += n_alloc; count -= n_alloc.
- Free:
  - n_free = popcount(free_en); ports are compacted in port order.
  - entry[tail+rank_f(i)] = free_addr[i]; tail += n_free at the edge.
  - Freed indices become allocatable the next cycle; allocation in the same cycle uses the registered count only.
- Simultaneous alloc and free in one cycle:
  - count_next = count - (grant ? n_alloc : 0) + n_free.
  - If count_next > PHYS_COUNT, the entire free group is dropped (no tail or count update from frees) and err_overflow is set; the alloc still proceeds.
- clk_en low: alloc_grant = 0; no pointer, count or storage update; frees are ignored.
- free_count and empty are registered views of count; after reset free_count = 96 and empty = 0.
- free_addr values below ARCH_COUNT are legal after reset, since architectural registers recycle.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- Defined:
  - Adds a PHYS_COUNT-bit in_free vector. Reset sets bits ARCH_COUNT..PHYS_COUNT-1.
  - A granted alloc clears the bit for each allocated index; an accepted free sets the bit for each freed index.
  - err_double_free is set (sticky) if a free targets an index whose bit is already set, or two free ports in the same cycle carry equal addresses.
  - A free that triggers err_double_free is still pushed.
- Undefined: no in_free vector; err_double_free is tied 0.

Test Plan:
- Reset, then idle -> free_count = 96, empty = 0, alloc_grant = 0, errors = 0, alloc_addr all 0.
- alloc_req = 4'b1111 -> grant = 1, alloc_addr = {32,33,34,35}; next cycle free_count = 92 and alloc_req = 4'b1010 gives port1 = 36, port3 = 37.
- Allocate down to count = 2, then alloc_req = 4'b0111 -> grant = 0, head and count unchanged; then 4'b0011 -> grant = 1, next cycle count = 0, empty = 1.
- At count = 0: free_en = 4'b0001, free_addr[0] = 5 with alloc_req = 4'b0001 -> grant = 0; next cycle count = 1, alloc gives 5; wrap-around is exercised by 40 further alloc/free rounds with correct FIFO order.
- At count = 127: free 2 entries with no alloc -> frees dropped, err_overflow = 1 and stays high until sync_rst.
- FREE_LIST_CHECK_EN: free index 40 (already free after reset) -> err_double_free = 1; without the macro, the same stimulus leaves err_double_free = 0.
